// File: rtl/mem_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_pkg;

    localparam int unsigned LATENCY_DEF = 2;
    localparam int unsigned AW_DEF      = 6;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LANE_W      = 8;
    localparam int unsigned N_LANES     = 4;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic              sb;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

    // One-hot byte enable for a byte lane (lane 0 = bits 7:0).
    function automatic logic [N_LANES-1:0] lane_be(input logic [1:0] lane);
        return N_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a processor and the memory responder.
interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_sb;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_sb, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_sb, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_array.sv
// Word storage with per-byte synchronous write and combinational read; never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic               clk,
    input  logic [N_LANES-1:0] be,
    input  logic [AW-1:0]      addr,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_LANES); i++) begin
            if (be[i]) begin
                mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request, answers LATENCY cycles later.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned AW      = AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned LAT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    req_t               held, bus_req, cur;
    logic               accept_c, commit_c, err_c;
    logic [N_LANES-1:0] be_c;
    logic [WORD_W-1:0]  wword_c, rword_c, merged_c;

    logic               ready_q, rsp_valid_q, rsp_err_q;
    logic [WORD_W-1:0]  rsp_rdata_q;

    assign bus_req = '{we: bus.req_we, sb: bus.req_sb, addr: bus.req_addr, wdata: bus.req_wdata};

    // With LATENCY=1 the commit edge is the accept edge, so use the live bus request.
    assign cur = (state == IDLE) ? bus_req : held;

    assign err_c = (cur.addr[WORD_W-1:AW+2] != '0)
                || (!(cur.we && cur.sb) && (cur.addr[1:0] != 2'b00));

    always_comb begin
        be_c = '0;
        if (cur.we && !err_c) begin
            be_c = cur.sb ? lane_be(cur.addr[1:0]) : {N_LANES{1'b1}};
        end
    end

    assign wword_c = cur.sb ? {N_LANES{cur.wdata[LANE_W-1:0]}} : cur.wdata;

    mem_array #(.AW(AW)) u_mem (
        .clk   (clk),
        .be    (be_c & {N_LANES{commit_c & reset}}),
        .addr  (cur.addr[AW+1:2]),
        .wdata (wword_c),
        .rdata (rword_c)
    );

    // Post-write view of the addressed word, returned in the response.
    always_comb begin
        merged_c = rword_c;
        for (int i = 0; i < int'(N_LANES); i++) begin
            if (be_c[i]) begin
                merged_c[i*LANE_W +: LANE_W] = wword_c[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        commit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_c = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        commit_c  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LAT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit_c  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            held        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept_c) begin
                held <= bus_req;
            end
            ready_q     <= (state_nxt == IDLE);
            rsp_valid_q <= commit_c;
            rsp_err_q   <= commit_c && err_c;
            rsp_rdata_q <= (commit_c && !err_c) ? merged_c : '0;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 and LATENCY=1 instances side by side.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_responder_if if0();
    mem_responder_if if1();

    mem_responder #(.LATENCY(2), .AW(6)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    mem_responder #(.LATENCY(1), .AW(6)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if0.req_ready : if1.req_ready;
    endfunction

    task automatic drive(input int sel, input logic v, input logic we, input logic sb,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_sb = sb;
            if0.req_addr = a;  if0.req_wdata = d;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_sb = sb;
            if1.req_addr = a;  if1.req_wdata = d;
        end
    endtask

    // Present a request until accepted; optionally register its expected response.
    task automatic issue(input int sel, input logic we, input logic sb, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input logic er, input bit push);
        @(negedge clk);
        drive(sel, 1'b1, we, sb, a, d);
        for (int n = 0; n < 32 && !rdy(sel); n++) @(negedge clk);
        if (!rdy(sel)) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else if (push) begin
            if (sel == 0) q0.push_back('{rd, er, cyc + 1});
            else          q1.push_back('{rd, er, cyc + 1});
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
        check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (if0.rsp_valid) begin
            if (q0.size() == 0) begin
                check("l2_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                check("l2_rdata", 64'(if0.rsp_rdata), 64'(e.rdata));
                check("l2_err", 64'(if0.rsp_err), 64'(e.err));
                check("l2_rsp_cycles", 64'(cyc - e.acc + 1), 64'd2);
            end
        end else begin
            check("l2_idle_rsp_zero", {31'd0, if0.rsp_err, if0.rsp_rdata}, 64'd0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (if1.rsp_valid) begin
            if (q1.size() == 0) begin
                check("l1_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("l1_rdata", 64'(if1.rsp_rdata), 64'(e.rdata));
                check("l1_err", 64'(if1.rsp_err), 64'(e.err));
                check("l1_rsp_cycles", 64'(cyc - e.acc + 1), 64'd1);
            end
        end else begin
            check("l1_idle_rsp_zero", {31'd0, if1.rsp_err, if1.rsp_rdata}, 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int accs[3];
        int n_acc;
        int lows;

        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(if0.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(if0.req_ready), 64'd1);

        // Word store/load, byte lane merge, address errors on the LATENCY=2 instance
        issue(0, 1, 0, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        issue(0, 0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1);
        issue(0, 1, 0, 32'h20,   32'h11223344, 32'h11223344, 0, 1);
        issue(0, 1, 1, 32'h22,   32'h000000AA, 32'h11AA3344, 0, 1);
        issue(0, 0, 0, 32'h20,   32'h0,        32'h11AA3344, 0, 1);
        issue(0, 0, 0, 32'h104,  32'h0,        32'h0,        1, 1);
        issue(0, 0, 0, 32'h06,   32'h0,        32'h0,        1, 1);
        issue(0, 1, 0, 32'h00,   32'h0BADF00D, 32'h0BADF00D, 0, 1);
        issue(0, 1, 0, 32'h101,  32'hCAFEF00D, 32'h0,        1, 1);
        issue(0, 0, 0, 32'h00,   32'h0,        32'h0BADF00D, 0, 1);
        issue(0, 1, 1, 32'h13,   32'hFFFFFF33, 32'h33ADBEEF, 0, 1);
        issue(0, 1, 0, 32'h12,   32'h12345678, 32'h0,        1, 1);
        issue(0, 1, 1, 32'h1000, 32'h00000055, 32'h0,        1, 1);
        issue(0, 0, 0, 32'h10,   32'h0,        32'h33ADBEEF, 0, 1);
        drain();

        // req_valid held high; junk stores presented while busy must be ignored
        n_acc = 0;
        lows = 0;
        @(negedge clk);
        for (int n = 0; n < 40 && n_acc < 3; n++) begin
            if (if0.req_ready) begin
                drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
                accs[n_acc] = cyc + 1;
                n_acc++;
                q0.push_back('{32'h33ADBEEF, 1'b0, cyc + 1});
            end else begin
                drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF);
                lows++;
            end
            if (n_acc < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("stream_accepts", 64'(n_acc), 64'd3);
        check("stream_gap_0", 64'(accs[1] - accs[0]), 64'd3);
        check("stream_gap_1", 64'(accs[2] - accs[1]), 64'd3);
        check("stream_ready_low", 64'(lows), 64'd4);
        issue(0, 0, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 1);
        drain();

        // Reset one cycle after accepting a store aborts it
        issue(0, 1, 0, 32'h30, 32'h12345678, 32'h12345678, 0, 1);
        drain();
        issue(0, 1, 0, 32'h30, 32'h00000005, 32'h0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(if0.rsp_valid), 64'd0);
            if (n < 2) check("abort_ready", 64'(if0.req_ready), 64'd1);
        end
        issue(0, 0, 0, 32'h30, 32'h0, 32'h12345678, 0, 1);
        drain();

        // LATENCY=1 instance: back-to-back store/load of the same word
        issue(1, 1, 0, 32'h3C, 32'h600DCAFE, 32'h600DCAFE, 0, 1);
        issue(1, 0, 0, 32'h3C, 32'h0,        32'h600DCAFE, 0, 1);
        issue(1, 1, 1, 32'h3C, 32'h0000007F, 32'h600DCA7F, 0, 1);
        issue(1, 0, 0, 32'h3C, 32'h0,        32'h600DCA7F, 0, 1);
        issue(1, 0, 0, 32'h3E, 32'h0,        32'h0,        1, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response (legal range 1..15).
REQ-002 SHALL have parameter AW, default 6, meaning word-address bits (64 words of storage).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  processor presents a request.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  request is a store.
REQ-008 SHALL have port req_sb  input  1  store is a byte store (ignored when req_we=0).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data; byte stores use bits 7:0.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  word read at response (post-write value for stores).
REQ-013 SHALL have port rsp_err  output  1  request rejected, valid only with rsp_valid.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on an edge where state=IDLE and req_valid=1, latching we, sb, addr, wdata.
REQ-016 SHALL, after accept, go to WAIT for LATENCY-1 cycles (down-counter), or directly to RESP when LATENCY=1.
REQ-017 SHALL assert rsp_valid exactly LATENCY cycles after the accepting edge, for exactly one cycle (state RESP), then return to IDLE.
REQ-018 SHALL provide no response backpressure; requester must take rsp_valid when it pulses.
REQ-019 SHALL commit stores and capture rsp_rdata on the edge entering RESP; a following request observes that write.
REQ-020 SHALL, for word stores, write all 32 bits to word addr[AW+1:2].
REQ-021 SHALL, for byte stores, write wdata[7:0] to lane addr[1:0] (lane 0 = bits 7:0, lane 3 = bits 31:24), other lanes unchanged.
REQ-022 SHALL flag rsp_err=1, suppress any write and return rsp_rdata=0 when addr[31:AW+2] is nonzero.
REQ-023 SHALL flag rsp_err=1, suppress any write and return rsp_rdata=0 for non-byte accesses with addr[1:0]!=0; byte stores with any addr[1:0] are legal.
REQ-024 SHALL ignore req_valid and input changes while in WAIT or RESP.
REQ-025 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid=0.

Reset
REQ-026 SHALL, when reset=0 at an edge, force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 in the first cycle after reset is released.
REQ-027 SHALL abort an in-flight request on reset with no write committed and no response issued.
REQ-028 SHALL NOT clear storage contents on reset.

Structure
REQ-029 SHALL take state enum, LATENCY default, AW default and lane constants from shared package mem_pkg.
REQ-030 SHALL place storage in one sub-module mem_array (2^AW x 32, synchronous write with 4-bit byte enable, combinational read).

Verification
REQ-031 SHALL cover: word store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-032 SHALL cover: word 0x11223344 at 0x20, byte store 0xAA to 0x22 -> subsequent load returns 0x11AA3344.
REQ-033 SHALL cover: load 0x104 -> rsp_err=1, rsp_rdata=0; load 0x06 -> rsp_err=1; word store to 0x101 leaves memory unchanged.
REQ-034 SHALL cover: req_valid held high continuously -> accepts spaced LATENCY+1 cycles, req_ready=0 during WAIT/RESP.
REQ-035 SHALL cover: store 0x5 to 0x30 accepted, reset=0 one cycle later -> no rsp_valid, later load 0x30 returns prior contents.
REQ-036 SHALL cover: LATENCY=1 build -> rsp_valid the cycle after accept, back-to-back store/load same address returns stored value.
